multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences the shared multicycle RV32 datapath: one memory port, one ALU, IR/OldPC/ALUOut/Data regs.
//  Decodes op/funct3 of the latched instruction and drives per-state datapath strobes.
//  Sits beside the datapath top; supports lw, sw, R-type, I-type ALU, beq, blt, jal, lui.
//  One instruction retires every 3-5 cycles.
// PARAMETERS
//  STATE_W       4   state register width (13 states used)
//  ILLEGAL_HALT  1   1: unknown op/funct3 -> S_HALT; 0: treated as NOP (S_DECODE -> S_FETCH)
// PORTS
//  clk        in   1  single clock, rising edge
//  resetn     in   1  asynchronous, active-low reset
//  op         in   7  instr[6:0] from IR
//  funct3     in   3  instr[14:12] from IR
//  zero       in   1  ALU result == 0
//  lt         in   1  ALU signed less-than (rs1 < rs2)
//  PCWrite    out  1  load PC
//  AdrSrc     out  1  0: PC, 1: ALUOut to memory address
//  MemWrite   out  1  memory write strobe
//  IRWrite    out  1  load IR and OldPC
//  ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA    out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
//  ALUSrcB    out  2  00 rs2, 01 ImmExt, 10 const 4
//  ALUOp      out  2  00 add, 01 sub/compare, 10 funct-decoded
//  ImmSrc     out  3  000 I, 001 S, 010 B, 011 J, 100 U; from op, valid in every state
//  RegWrite   out  1  register file write strobe
//  instr_done out  1  1-cycle pulse on the last cycle of each instruction
//  halted     out  1  high while in S_HALT
// BEHAVIOUR
//  - Reset:
//    - resetn=0 forces state=S_FETCH asynchronously.
//    - All outputs are gated to 0 while resetn=0 (PCWrite/IRWrite must not fire during reset).
//    - Reset mid-instruction aborts it; nothing is committed.
//  - States and transitions (strobes not listed are 0):
//    - S_FETCH: IRWrite=1, PCWrite=1, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10 -> S_DECODE
//    - S_DECODE: SrcA=01, SrcB=01, ALUOp=00 (branch/jal target to ALUOut). Next state by op:
//      - lw/sw -> S_MEMADR
//      - R -> S_EXECR
//      - I-ALU -> S_EXECI
//      - beq/blt -> S_BRANCH
//      - jal -> S_JAL
//      - lui -> S_LUI
//      - else -> S_HALT or S_FETCH, per ILLEGAL_HALT
//    - S_MEMADR: SrcA=10, SrcB=01, ALUOp=00 -> S_MEMREAD (lw) or S_MEMWRITE (sw)
//    - S_MEMREAD: AdrSrc=1 -> S_MEMWB
//    - S_MEMWB: ResultSrc=01, RegWrite=1 -> S_FETCH
//    - S_MEMWRITE: AdrSrc=1, MemWrite=1 -> S_FETCH
//    - S_EXECR: SrcA=10, SrcB=00, ALUOp=10 -> S_ALUWB
//    - S_EXECI: SrcA=10, SrcB=01, ALUOp=10 -> S_ALUWB
//    - S_ALUWB: ResultSrc=00, RegWrite=1 -> S_FETCH
//    - S_BRANCH: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00 -> S_FETCH
//      - PCWrite = (funct3==000 & zero) | (funct3==100 & lt)
//    - S_JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> S_ALUWB (rd = OldPC+4)
//    - S_LUI: SrcA=11, SrcB=01, ALUOp=00 -> S_ALUWB
//    - S_HALT: all strobes 0, halted=1; exits only via reset.
//  - Latency: lw 5, sw/R/I/jal/lui 4, branch 3 cycles.
//  - instr_done is high in S_MEMWB, S_MEMWRITE, S_ALUWB and S_BRANCH, and in S_DECODE for a NOP'd illegal instruction.
//  - Outputs are combinational decode of the state register (plus op/funct3/zero/lt); no output registers.
//  - Illegal branch funct3 (not 000/100) is treated as an illegal op.
// CONFIGURATION
//  MULTICYCLE_MEM_WAIT_EN defined:
//    - Adds input mem_ready (1 bit).
//    - S_FETCH, S_MEMREAD and S_MEMWRITE hold their address/strobe outputs until mem_ready=1.
//    - In S_FETCH, IRWrite and PCWrite assert only in the mem_ready=1 cycle.
//    - In S_MEMWRITE, MemWrite is held until mem_ready=1; instr_done pulses only in that cycle.
//    - Each memory state lasts 1+N cycles for N wait cycles.
//  MULTICYCLE_MEM_WAIT_EN not defined: no mem_ready port; memory states last exactly 1 cycle.
// STRUCTURE
//  - riscv_defs.vh (shared include):
//    - opcode localparams OP_LW/OP_SW/OP_R/OP_I/OP_BR/OP_JAL/OP_LUI
//    - funct3 F3_BEQ/F3_BLT
//    - ImmSrc, ResultSrc, ALUSrcA/B and ALUOp encodings
//    - S_* state codes
//  - One sub-module: imm_src_dec (op -> ImmSrc, combinational). It is also reusable by the pipelined decoder.
// TESTING
//  - Reset: resetn=0 mid-S_MEMREAD -> state=S_FETCH; all outputs 0 until resetn=1; first cycle after release IRWrite=1.
//  - lw (op=0000011): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; instr_done at cycle 5.
//  - sw (op=0100011): MemWrite=1 and AdrSrc=1 in exactly cycle 4; ImmSrc=001 throughout; RegWrite never 1.
//  - beq funct3=000: zero=1 -> PCWrite=1 in cycle 3; zero=0 -> PCWrite=0. blt funct3=100 with lt=1 -> PCWrite=1.
//  - jal: PCWrite in cycle 3 with ResultSrc=00; cycle 4 RegWrite=1; lui: SrcA=11, ImmSrc=100, RegWrite in cycle 4.
//  - op=1111111 with ILLEGAL_HALT=1 -> halted=1 from cycle 3 and held for 20 cycles; with MEM_WAIT_EN, mem_ready=0 for 3 cycles in FETCH -> IRWrite pulses once.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared RV32 multicycle definitions: opcodes, funct3, datapath mux encodings, FSM state codes.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BLT = 3'b100;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_HALT     = 4'd12
    } state_t;

endpackage

// File: rtl/multicycle_ctrl_imm_src_dec.sv
// Opcode -> immediate format select; pure combinational so the pipelined decoder can reuse it.
module imm_src_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [2:0] imm_src_o
);

    always_comb begin
        unique case (op_i)
            OP_SW:   imm_src_o = IMM_S;
            OP_BR:   imm_src_o = IMM_B;
            OP_JAL:  imm_src_o = IMM_J;
            OP_LUI:  imm_src_o = IMM_U;
            default: imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the shared multicycle RV32 datapath.
// Optional memory handshake (mem_ready stalls) enabled by MULTICYCLE_MEM_WAIT_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int STATE_W      = 4,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       halted
);

    logic [STATE_W-1:0] state_q, state_d;
    state_t             cur, nxt, dec_tgt;
    logic               illegal, mem_rdy, br_taken;
    logic [2:0]         imm_src;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    assign cur      = state_t'(state_q[3:0]);
    assign br_taken = ((funct3 == F3_BEQ) & zero) | ((funct3 == F3_BLT) & lt);

    imm_src_dec u_imm_src_dec (
        .op_i      (op),
        .imm_src_o (imm_src)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= STATE_W'(S_FETCH);
        else         state_q <= state_d;
    end

    // Opcode decode; branches with funct3 other than beq/blt count as illegal.
    always_comb begin
        illegal = 1'b0;
        dec_tgt = S_FETCH;
        unique case (op)
            OP_LW, OP_SW: dec_tgt = S_MEMADR;
            OP_R:         dec_tgt = S_EXECR;
            OP_I:         dec_tgt = S_EXECI;
            OP_BR:        if (funct3 == F3_BEQ || funct3 == F3_BLT) dec_tgt = S_BRANCH;
                          else                                     illegal = 1'b1;
            OP_JAL:       dec_tgt = S_JAL;
            OP_LUI:       dec_tgt = S_LUI;
            default:      illegal = 1'b1;
        endcase
    end

    always_comb begin
        nxt = S_FETCH;
        unique case (cur)
            S_FETCH:    nxt = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE:   nxt = illegal ? (ILLEGAL_HALT ? S_HALT : S_FETCH) : dec_tgt;
            S_MEMADR:   nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt = mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: nxt = mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    nxt = S_ALUWB;
            S_EXECI:    nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_BRANCH:   nxt = S_FETCH;
            S_JAL:      nxt = S_ALUWB;
            S_LUI:      nxt = S_ALUWB;
            S_HALT:     nxt = S_HALT;
            default:    nxt = S_FETCH;
        endcase
        state_d = STATE_W'(nxt);
    end

    // Everything is forced low during reset so no PC/IR load can slip through.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALU_ADD;
        ImmSrc     = imm_src;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        unique case (cur)
            S_FETCH: begin
                IRWrite   = mem_rdy;
                PCWrite   = mem_rdy;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                instr_done = illegal & ~ILLEGAL_HALT;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_rdy;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALU_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUOp      = ALU_SUB;
                PCWrite    = br_taken;
                instr_done = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
        if (!resetn) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUOp      = 2'b00;
            ImmSrc     = 3'b000;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
            halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle strobe vectors against hand-encoded expectations.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero, lt;
`ifdef MULTICYCLE_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .op         (op),
        .funct3     (funct3),
        .zero       (zero),
        .lt         (lt),
`ifdef MULTICYCLE_MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .halted     (halted)
    );

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,RegWrite,instr_done,halted}
    logic [17:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUOp, ImmSrc, RegWrite, instr_done, halted};

    function automatic logic [17:0] v(input bit pcw, input bit adr, input bit mw, input bit irw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] aop,
                                      input logic [2:0] imm, input bit rw, input bit done,
                                      input bit hlt);
        return {pcw, adr, mw, irw, rs, sa, sb, aop, imm, rw, done, hlt};
    endfunction

    // Hand-encoded per-state vectors (imm = expected ImmSrc for the current op)
    function automatic logic [17:0] vF(input logic [2:0] imm);  return v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,imm,0,0,0); endfunction
    function automatic logic [17:0] vD(input logic [2:0] imm);  return v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,imm,0,0,0); endfunction
    function automatic logic [17:0] vMA(input logic [2:0] imm); return v(0,0,0,0,2'b00,2'b10,2'b01,2'b00,imm,0,0,0); endfunction
    function automatic logic [17:0] vMR(input logic [2:0] imm); return v(0,1,0,0,2'b00,2'b00,2'b00,2'b00,imm,0,0,0); endfunction
    function automatic logic [17:0] vMWB(input logic [2:0] imm); return v(0,0,0,0,2'b01,2'b00,2'b00,2'b00,imm,1,1,0); endfunction
    function automatic logic [17:0] vMW(input logic [2:0] imm); return v(0,1,1,0,2'b00,2'b00,2'b00,2'b00,imm,0,1,0); endfunction
    function automatic logic [17:0] vXR(input logic [2:0] imm); return v(0,0,0,0,2'b00,2'b10,2'b00,2'b10,imm,0,0,0); endfunction
    function automatic logic [17:0] vXI(input logic [2:0] imm); return v(0,0,0,0,2'b00,2'b10,2'b01,2'b10,imm,0,0,0); endfunction
    function automatic logic [17:0] vWB(input logic [2:0] imm); return v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,imm,1,1,0); endfunction
    function automatic logic [17:0] vBR(input bit tk);          return v(tk,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0,1,0); endfunction
    function automatic logic [17:0] vJ();                       return v(1,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b011,0,0,0); endfunction
    function automatic logic [17:0] vL();                       return v(0,0,0,0,2'b00,2'b11,2'b01,2'b00,3'b100,0,0,0); endfunction
    function automatic logic [17:0] vH(input logic [2:0] imm);  return v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,imm,0,0,1); endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check the current cycle's outputs, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [17:0] e);
        #1;
        chk(tag, {14'd0, obs}, {14'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input string tag, input logic [2:0] f3, input bit z, input bit l, input bit tk);
        op = 7'b1100011; funct3 = f3; zero = z; lt = l;
        cyc({tag, "_F"}, vF(3'b010));
        cyc({tag, "_D"}, vD(3'b010));
        cyc({tag, "_BR"}, vBR(tk));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; op = 7'b0000011; funct3 = 3'b000; zero = 1'b0; lt = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", {14'd0, obs}, 32'd0);
        resetn = 1'b1;

        // lw aborted by reset while in MEMREAD
        cyc("abort_F", vF(3'b000));
        cyc("abort_D", vD(3'b000));
        cyc("abort_MA", vMA(3'b000));
        resetn = 1'b0;
        #1 chk("reset_mid_memread", {14'd0, obs}, 32'd0);
        @(posedge clk); #1;
        chk("reset_held", {14'd0, obs}, 32'd0);
        resetn = 1'b1;

        // lw: 5 cycles
        cyc("lw_F", vF(3'b000));
        cyc("lw_D", vD(3'b000));
        cyc("lw_MA", vMA(3'b000));
        cyc("lw_MR", vMR(3'b000));
        cyc("lw_WB", vMWB(3'b000));

        // sw: 4 cycles, S immediate throughout
        op = 7'b0100011;
        cyc("sw_F", vF(3'b001));
        cyc("sw_D", vD(3'b001));
        cyc("sw_MA", vMA(3'b001));
        cyc("sw_MW", vMW(3'b001));

        op = 7'b0110011;
        cyc("r_F", vF(3'b000));
        cyc("r_D", vD(3'b000));
        cyc("r_EX", vXR(3'b000));
        cyc("r_WB", vWB(3'b000));

        op = 7'b0010011;
        cyc("i_F", vF(3'b000));
        cyc("i_D", vD(3'b000));
        cyc("i_EX", vXI(3'b000));
        cyc("i_WB", vWB(3'b000));

        branch("beq_tk", 3'b000, 1'b1, 1'b0, 1'b1);
        branch("beq_nt", 3'b000, 1'b0, 1'b1, 1'b0);
        branch("blt_tk", 3'b100, 1'b0, 1'b1, 1'b1);
        branch("blt_nt", 3'b100, 1'b1, 1'b0, 1'b0);

        op = 7'b1101111; funct3 = 3'b000; zero = 1'b0; lt = 1'b0;
        cyc("jal_F", vF(3'b011));
        cyc("jal_D", vD(3'b011));
        cyc("jal_J", vJ());
        cyc("jal_WB", vWB(3'b011));

        op = 7'b0110111;
        cyc("lui_F", vF(3'b100));
        cyc("lui_D", vD(3'b100));
        cyc("lui_L", vL());
        cyc("lui_WB", vWB(3'b100));

`ifdef MULTICYCLE_MEM_WAIT_EN
        // fetch and load stalled by mem_ready
        op = 7'b0000011; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("wait_F_stall", v(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0));
        mem_ready = 1'b1;
        cyc("wait_F", vF(3'b000));
        cyc("wait_D", vD(3'b000));
        cyc("wait_MA", vMA(3'b000));
        mem_ready = 1'b0;
        cyc("wait_MR_stall", vMR(3'b000));
        cyc("wait_MR_stall2", vMR(3'b000));
        mem_ready = 1'b1;
        cyc("wait_MR", vMR(3'b000));
        cyc("wait_WB", vMWB(3'b000));
        op = 7'b0100011;
        cyc("wsw_F", vF(3'b001));
        cyc("wsw_D", vD(3'b001));
        cyc("wsw_MA", vMA(3'b001));
        mem_ready = 1'b0;
        cyc("wsw_MW_stall", v(0,1,1,0,2'b00,2'b00,2'b00,2'b00,3'b001,0,0,0));
        mem_ready = 1'b1;
        cyc("wsw_MW", vMW(3'b001));
        cyc("wsw_next_F", vF(3'b001));
        resetn = 1'b0;
        #1;
        @(posedge clk); #1;
        resetn = 1'b1;
`endif

        // branch with bad funct3 halts
        op = 7'b1100011; funct3 = 3'b001;
        cyc("badbr_F", vF(3'b010));
        cyc("badbr_D", vD(3'b010));
        cyc("badbr_H", vH(3'b010));
        resetn = 1'b0;
        #1 chk("reset_from_halt", {14'd0, obs}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // unknown opcode halts and stays halted
        op = 7'b1111111; funct3 = 3'b000;
        cyc("ill_F", vF(3'b000));
        cyc("ill_D", vD(3'b000));
        for (int i = 0; i < 20; i++)
            cyc("ill_halt", vH(3'b000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
